load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 255, giving the maximum cycles spent in REQ+WAIT before abort.
REQ-002 The block SHALL have port clk_cpu, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port ls_valid, input, 1, CPU request strobe, sampled only while ls_ready=1.
REQ-005 The block SHALL have port ls_op, input, 6, MIPS opcode: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B.
REQ-006 The block SHALL have ports ls_adrs and ls_wdata, input, 32 each, the byte address and the store data (right-justified).
REQ-007 The block SHALL have ports ls_ready, ls_done, ls_err, output, 1 each: idle/accepting, one-cycle completion pulse, and error qualifier valid with ls_done.
REQ-008 The block SHALL have port ls_rdata, output, 32, the extended load result, valid while ls_done=1.
REQ-009 The block SHALL have ports mem_req, mem_we, output, 1 each; mem_adrs, output, 32, word-aligned (bits 1:0 = 0); mem_wdata, output, 32; mem_be, output, 4.
REQ-010 The block SHALL have ports mem_gnt, mem_rvalid, input, 1 each; mem_rdata, input, 32.

Function
REQ-011 The FSM states SHALL be IDLE, REQ, WAIT and DONE; every output SHALL be registered.
REQ-012 IDLE: ls_ready=1; ls_valid=1 with a legal op latches op, address and data and moves to REQ; an illegal op moves to DONE with ls_err=1 and issues no memory request.
REQ-013 REQ: mem_req=1 with address, data, we and be held stable until mem_gnt=1; a grant on a store goes to DONE, a grant on a load goes to WAIT.
REQ-014 WAIT: mem_rvalid=1 captures mem_rdata and goes to DONE; mem_rvalid in any other state SHALL be ignored.
REQ-015 DONE: ls_done=1 for exactly one cycle, then IDLE; ls_valid is ignored in REQ, WAIT and DONE.
REQ-016 Latency: ls_valid accepted in cycle N gives mem_req in N+1; a store granted in N+1 gives ls_done in N+2; a load granted in N+1 with rvalid in N+2 gives ls_done in N+3.
REQ-017 Byte lanes SHALL be little-endian: lane k = bits 8k+7:8k at byte address offset k.
REQ-018 Byte enables SHALL be: byte = 1<<adrs[1:0]; half = 0011 or 1100 by adrs[1]; word = 1111; the store data SHALL be replicated into the enabled lanes.
REQ-019 A load SHALL select the addressed lane(s), then sign-extend for lb/lh and zero-extend for lbu/lhu; lw passes through.
REQ-020 A cycle counter SHALL run in REQ and WAIT; on reaching WAIT_MAX it SHALL drop mem_req, go to DONE with ls_err=1 and ls_rdata=0.
REQ-021 ls_rdata SHALL hold its value until the next DONE.

Reset
REQ-022 Reset SHALL force IDLE, ls_ready=1, and ls_done, ls_err, mem_req, mem_we to 0; it SHALL clear ls_rdata, mem_adrs, mem_wdata, mem_be and the counter to 0.
REQ-023 Reset during REQ or WAIT SHALL abandon the transaction with no ls_done; a later mem_rvalid SHALL be ignored.

Configuration
REQ-024 With LSU_MISALIGN_TRAP_EN defined, a halfword access with adrs[0]=1 or a word access with adrs[1:0]≠0 SHALL go IDLE->DONE with ls_err=1 and no memory request.
REQ-025 Without LSU_MISALIGN_TRAP_EN, misalignment SHALL be ignored: the low bits are forced to the natural alignment (half: bit 0 = 0; word: bits 1:0 = 00) and no error is raised.

Verification
REQ-026 The bench SHALL check: sb, adrs 0x103, wdata 0x000000A5 -> mem_adrs 0x100, mem_be 1000, mem_wdata 0xA5A5A5A5, mem_we=1, ls_done at N+2 with gnt at N+1.
REQ-027 The bench SHALL check: lb, adrs 0x201, mem_rdata 0x1234_80FF -> ls_rdata 0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-028 The bench SHALL check: lh, adrs 0x12, mem_rdata 0x8001_7FFF -> ls_rdata 0xFFFF8001, mem_be 1100.
REQ-029 The bench SHALL check: lw with mem_gnt held low and WAIT_MAX=4 -> mem_req high 4 cycles then drops, ls_done=1 with ls_err=1.
REQ-030 The bench SHALL check: lw, adrs 0x2, with the macro defined -> no mem_req, ls_err=1; without it -> mem_adrs 0x0, ls_err=0.
REQ-031 The bench SHALL check: reset asserted in WAIT, then rvalid -> no ls_done, ls_ready=1 the cycle after reset; op 0x3F -> ls_err=1 and no mem_req.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding CPU access at a time to a word-wide memory port, with byte-lane steering and load extension.
// Optional build macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of silently aligning them.
module load_store_unit #(
    parameter int WAIT_MAX = 255
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        ls_valid,
    input  logic [5:0]  ls_op,
    input  logic [31:0] ls_adrs,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_adrs,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    // Counter must be able to hold WAIT_MAX itself (a load granted in the final REQ cycle).
    localparam int            CW       = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t        state_reg;
    logic [5:0]    op_reg;
    logic [1:0]    lane_reg;
    logic [CW-1:0] cnt_reg;

    logic          op_legal_next;
    logic          op_load_next;
    logic          trap_next;
    size_t         size_next;
    logic [1:0]    lane_next;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;

    // Request decode: size, lane, byte enables and replicated store data.
    always_comb begin
        op_legal_next = 1'b1;
        op_load_next  = 1'b1;
        size_next     = SZ_WORD;
        case (ls_op)
            OP_LB, OP_LBU: size_next = SZ_BYTE;
            OP_LH, OP_LHU: size_next = SZ_HALF;
            OP_LW:         size_next = SZ_WORD;
            OP_SB: begin
                op_load_next = 1'b0;
                size_next    = SZ_BYTE;
            end
            OP_SH: begin
                op_load_next = 1'b0;
                size_next    = SZ_HALF;
            end
            OP_SW:         op_load_next = 1'b0;
            default:       op_legal_next = 1'b0;
        endcase

        lane_next  = 2'b00;
        be_next    = 4'b1111;
        wdata_next = ls_wdata;
        case (size_next)
            SZ_BYTE: begin
                lane_next  = ls_adrs[1:0];
                be_next    = 4'b0001 << ls_adrs[1:0];
                wdata_next = {4{ls_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_next  = {ls_adrs[1], 1'b0};
                be_next    = ls_adrs[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{ls_wdata[15:0]}};
            end
            default: begin
                lane_next  = 2'b00;
                be_next    = 4'b1111;
                wdata_next = ls_wdata;
            end
        endcase

`ifdef LSU_MISALIGN_TRAP_EN
        trap_next = !op_legal_next
                  || ((size_next == SZ_HALF) && ls_adrs[0])
                  || ((size_next == SZ_WORD) && (ls_adrs[1:0] != 2'b00));
`else
        trap_next = !op_legal_next;
`endif
    end

    logic [7:0]  rbyte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_value;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rbyte[gi] = mem_rdata[8*gi +: 8];
    end

    always_comb begin
        sel_byte = rbyte[lane_reg];
        sel_half = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_reg)
            OP_LB:   load_value = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_value = {24'h0, sel_byte};
            OP_LH:   load_value = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_value = {16'h0, sel_half};
            default: load_value = mem_rdata;
        endcase
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= 6'h0;
            lane_reg  <= 2'b00;
            cnt_reg   <= '0;
            ls_ready  <= 1'b1;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_adrs  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ls_valid) begin
                        ls_ready <= 1'b0;
                        if (trap_next) begin
                            state_reg <= DONE;
                            ls_done   <= 1'b1;
                            ls_err    <= 1'b1;
                            ls_rdata  <= 32'h0;
                        end else begin
                            state_reg <= REQ;
                            op_reg    <= ls_op;
                            lane_reg  <= lane_next;
                            cnt_reg   <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= !op_load_next;
                            mem_adrs  <= {ls_adrs[31:2], 2'b00};
                            mem_wdata <= wdata_next;
                            mem_be    <= be_next;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt_reg <= cnt_reg + CW'(1);
                        if (mem_we) begin
                            state_reg <= DONE;
                            ls_done   <= 1'b1;
                            ls_err    <= 1'b0;
                            ls_rdata  <= 32'h0;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        mem_req   <= 1'b0;
                        state_reg <= DONE;
                        ls_done   <= 1'b1;
                        ls_err    <= 1'b1;
                        ls_rdata  <= 32'h0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_reg <= DONE;
                        ls_done   <= 1'b1;
                        ls_err    <= 1'b0;
                        ls_rdata  <= load_value;
                    end else if (cnt_reg >= CNT_LAST) begin
                        state_reg <= DONE;
                        ls_done   <= 1'b1;
                        ls_err    <= 1'b1;
                        ls_rdata  <= 32'h0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ls_done   <= 1'b0;
                    ls_err    <= 1'b0;
                    ls_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized accesses and memory timing against a byte-lane reference model.
module tb_load_store_unit;
    localparam int WAIT_MAX = 4;
    localparam int NEVER    = 99;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        clk_cpu = 1'b0;
    logic        reset = 1'b1;
    logic        ls_valid = 1'b0;
    logic [5:0]  ls_op = 6'h0;
    logic [31:0] ls_adrs = 32'h0;
    logic [31:0] ls_wdata = 32'h0;
    logic        ls_ready, ls_done, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_adrs, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    load_store_unit #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk_cpu(clk_cpu), .reset(reset),
        .ls_valid(ls_valid), .ls_op(ls_op), .ls_adrs(ls_adrs), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adrs(mem_adrs), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        bit          chk;
    } resp_t;

    typedef struct {
        logic [31:0] adrs;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        int          len;
    } req_t;

    resp_t resp_q[$];
    req_t  req_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;

    always @(posedge clk_cpu) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void decode(input logic [5:0] op, output bit legal, output bit load,
                                   output int size, output bit sgn);
        legal = 1; load = 1; sgn = 0; size = 4;
        case (op)
            OP_LB:   begin size = 1; sgn = 1; end
            OP_LH:   begin size = 2; sgn = 1; end
            OP_LW:   size = 4;
            OP_LBU:  size = 1;
            OP_LHU:  size = 2;
            OP_SB:   begin size = 1; load = 0; end
            OP_SH:   begin size = 2; load = 0; end
            OP_SW:   load = 0;
            default: legal = 0;
        endcase
    endfunction

    // Shift the addressed lane down, keep size*8 bits, then extend.
    function automatic logic [31:0] model_load(input logic [5:0] op, input int lane, input logic [31:0] word);
        bit legal, load, sgn;
        int size;
        logic [63:0] v, mask;
        decode(op, legal, load, size, sgn);
        v    = 64'(word) >> (8 * lane);
        mask = (64'd1 << (8 * size)) - 64'd1;
        v    = v & mask;
        if (sgn && v[8*size-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ls_ready"}, 32'(ls_ready), 32'd1);
        check({tag, "_ls_done"}, 32'(ls_done), 32'd0);
        check({tag, "_ls_err"}, 32'(ls_err), 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_ls_rdata"}, ls_rdata, 32'h0);
        check({tag, "_mem_adrs"}, mem_adrs, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_mem_be"}, 32'(mem_be), 32'h0);
    endtask

    // g: REQ cycles before the grant (NEVER = no grant); r: WAIT cycles before rvalid (NEVER = none).
    task automatic run_txn(input logic [5:0] op, input logic [31:0] adrs, input logic [31:0] wdata,
                           input logic [31:0] rword, input int g, input int r);
        bit legal, load, sgn, trap, timeout;
        int size, lane, n, d, rv_c, k;
        logic [31:0] aligned;
        resp_t rs;
        req_t rq;
        decode(op, legal, load, size, sgn);
        trap = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
        if (legal && (adrs % size) != 0) trap = 1;
`endif
        k = 0;
        while (!ls_ready && k < 20) begin
            @(posedge clk_cpu); #1;
            k++;
        end
        check("ls_ready_before_issue", 32'(ls_ready), 32'd1);
        n    = cyc;
        rv_c = -1;
        rs.chk = 0;
        rs.rdata = 32'h0;
        if (trap) begin
            d = n + 1;
            rs.err = 1;
        end else begin
            aligned = adrs & ~32'(size - 1);
            lane    = int'(aligned % 4);
            rq.adrs = aligned - 32'(lane);
            rq.we   = !load;
            rq.be   = 4'(((1 << size) - 1) << lane);
            for (int b = 0; b < 4; b++) rq.wdata[8*b +: 8] = wdata[8*(b % size) +: 8];
            rq.len  = (g < WAIT_MAX) ? g + 1 : WAIT_MAX;
            req_q.push_back(rq);
            timeout = (g >= WAIT_MAX) || (load && (g + r + 2 > WAIT_MAX));
            if (timeout) begin
                d = n + 1 + WAIT_MAX;
                rs.err = 1;
                rs.chk = 1;
            end else if (!load) begin
                d = n + g + 2;
                rs.err = 0;
            end else begin
                d = n + g + r + 3;
                rv_c = g + 2 + r;
                rs.err = 0;
                rs.rdata = model_load(op, lane, rword);
                rs.chk = 1;
            end
        end
        rs.cyc = d;
        resp_q.push_back(rs);
        $display("[TB] txn op=%02h adrs=%08h wdata=%08h rword=%08h g=%0d r=%0d exp_err=%0d exp_rdata=%08h done@+%0d",
                 op, adrs, wdata, rword, g, r, rs.err, rs.rdata, d - n);

        ls_valid = 1; ls_op = op; ls_adrs = adrs; ls_wdata = wdata;
        mem_gnt = 0; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        for (int c = 1; c <= d - n; c++) begin
            @(posedge clk_cpu); #1;
            // Busy cycles: CPU noise must be ignored; junk rvalid only where no WAIT is live.
            ls_valid = 1'($urandom); ls_op = 6'($urandom); ls_adrs = $urandom; ls_wdata = $urandom;
            mem_gnt = !trap && (c == g + 1);
            if (c == rv_c) begin
                mem_rvalid = 1; mem_rdata = rword;
            end else if (c <= g + 1 || c == d - n) begin
                mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            end else begin
                mem_rvalid = 0;
            end
        end
        @(posedge clk_cpu); #1;
        ls_valid = 0; mem_gnt = 0; mem_rvalid = 0;
    endtask

    task automatic reset_in_wait();
        req_t rq;
        rq.adrs = 32'h40; rq.wdata = 32'h0; rq.be = 4'hF; rq.we = 0; rq.len = 1;
        req_q.push_back(rq);
        $display("[TB] txn reset-in-WAIT lw adrs=00000040 (no ls_done expected)");
        ls_valid = 1; ls_op = OP_LW; ls_adrs = 32'h40; ls_wdata = 32'h0;
        @(posedge clk_cpu); #1;
        ls_valid = 0; mem_gnt = 1;
        @(posedge clk_cpu); #1;
        mem_gnt = 0; reset = 1;
        @(posedge clk_cpu); #1;
        reset = 0; mem_rvalid = 1; mem_rdata = $urandom;
        @(negedge clk_cpu);
        check_reset_values("after_wait_reset");
        @(posedge clk_cpu); #1;
        mem_rvalid = 0;
        repeat (3) @(posedge clk_cpu);
        #1;
    endtask

    // Response monitor.
    resp_t exp_resp;
    initial forever begin
        @(negedge clk_cpu);
        if (ls_done === 1'b1) begin
            if (resp_q.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL unexpected_ls_done: got ls_done=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_resp = resp_q.pop_front();
                check("ls_done_cycle", 32'(cyc), 32'(exp_resp.cyc));
                check("ls_err", 32'(ls_err), 32'(exp_resp.err));
                if (exp_resp.chk) check("ls_rdata", ls_rdata, exp_resp.rdata);
            end
        end
    end

    // Memory-side monitor.
    req_t cur_req;
    bit   cur_valid = 0;
    logic req_prev = 0;
    int   req_len = 0;
    initial forever begin
        @(negedge clk_cpu);
        if (mem_req === 1'b1 && !req_prev) begin
            req_len = 0;
            if (req_q.size() == 0) begin
                cur_valid = 0;
                tests++; fails++;
                $display("[TB] FAIL unexpected_mem_req: got mem_req=1 expected 0 (cycle %0d)", cyc);
            end else begin
                cur_req = req_q.pop_front();
                cur_valid = 1;
            end
        end
        if (mem_req === 1'b1) begin
            req_len++;
            if (cur_valid) begin
                check("mem_adrs", mem_adrs, cur_req.adrs);
                check("mem_be", 32'(mem_be), 32'(cur_req.be));
                check("mem_we", 32'(mem_we), 32'(cur_req.we));
                if (cur_req.we) check("mem_wdata", mem_wdata, cur_req.wdata);
            end
        end
        if (mem_req !== 1'b1 && req_prev && cur_valid) begin
            check("mem_req_high_cycles", 32'(req_len), 32'(cur_req.len));
            cur_valid = 0;
        end
        req_prev = (mem_req === 1'b1);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [5:0] legal_ops [8];
    logic [5:0] load_ops [5];

    initial begin
        int sel, g, r;
        bit lg, ld, sg;
        int sz;
        logic [5:0] op;
        legal_ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        load_ops  = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};

        reset = 1;
        repeat (2) @(posedge clk_cpu);
        @(negedge clk_cpu);
        check_reset_values("reset");
        @(posedge clk_cpu); #1;
        reset = 0;

        run_txn(OP_SB, 32'h103, 32'h000000A5, 32'h0, 0, 0);
        run_txn(OP_LB, 32'h201, 32'h0, 32'h123480FF, 0, 0);
        run_txn(OP_LBU, 32'h201, 32'h0, 32'h123480FF, 0, 0);
        run_txn(OP_LH, 32'h12, 32'h0, 32'h80017FFF, 0, 0);
        run_txn(OP_LW, 32'h80, 32'h0, 32'h0, NEVER, 0);
        run_txn(OP_LW, 32'h2, 32'h0, 32'hCAFEF00D, 0, 0);
        run_txn(6'h3F, 32'h40, 32'h0, 32'h0, 0, 0);
        run_txn(OP_LHU, 32'h42, 32'h0, 32'hBEEF1234, 1, 1);
        reset_in_wait();

        for (int t = 0; t < 250; t++) begin
            sel = $urandom_range(0, 19);
            op  = legal_ops[$urandom_range(0, 7)];
            decode(op, lg, ld, sz, sg);
            g = 0; r = 0;
            if (sel < 2) begin
                do begin
                    op = 6'($urandom);
                    decode(op, lg, ld, sz, sg);
                end while (lg);
            end else if (sel < 5) begin
                g = NEVER;
            end else if (sel < 7) begin
                op = load_ops[$urandom_range(0, 4)];
                g = $urandom_range(0, 1);
                r = NEVER;
            end else if (ld) begin
                g = $urandom_range(0, 1);
                r = $urandom_range(0, 2 - g);
            end else begin
                g = $urandom_range(0, 3);
            end
            run_txn(op, $urandom, $urandom, $urandom, g, r);
        end

        repeat (5) @(posedge clk_cpu);
        #1;
        check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        check("req_queue_drained", 32'(req_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
